// File: rtl/compare_decision_tracker.sv
// compare_decision_tracker
//
// Sits directly behind the 8-bit comparator. It counts how often each
// compare outcome (gt / lt / eq) was seen and produces a debounced,
// hysteretic decision that only moves after STABLE_N consecutive identical
// valid results. The aim is to give downstream control logic a stable view
// of a noisy compare stream.
//
// Parameters:
//   CNT_W    - width of each saturating outcome counter (>= 2)
//   STABLE_N - consecutive identical valid results needed to lock (>= 1)
//
// Ports:
//   clk             - rising-edge clock
//   rst             - asynchronous, active-high reset
//   in_valid        - comparator flags are valid this cycle
//   A_gt_B          - comparator greater-than flag
//   A_lt_B          - comparator less-than flag
//   A_eq_B          - comparator equal flag
//   clear           - synchronous clear of all state; it wins over in_valid
//   gt_count        - number of accepted gt results (saturating)
//   lt_count        - number of accepted lt results (saturating)
//   eq_count        - number of accepted eq results (saturating)
//   decision        - locked outcome: 00 none, 01 gt, 10 lt, 11 eq
//   decision_valid  - decision != 00
//   decision_change - one-cycle pulse when decision takes a new value
//   onehot_err      - sticky flag: a non-one-hot vector arrived with in_valid
//
// Build option:
//   COMPARE_ONEHOT_CHECK_EN - when defined, valid flag vectors that are not
//   exactly one-hot are rejected and set onehot_err. When undefined, flags
//   decode by priority eq > gt > lt, a valid 000 vector is ignored, and
//   onehot_err is tied to 0.

module compare_decision_tracker #(
    parameter int CNT_W    = 16,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A_gt_B,
    input  logic             A_lt_B,
    input  logic             A_eq_B,
    input  logic             clear,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [1:0]       decision,
    output logic             decision_valid,
    output logic             decision_change,
    output logic             onehot_err
);

    localparam int               RUN_W   = $clog2(STABLE_N + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] OUT_NONE = 2'b00;
    localparam logic [1:0] OUT_GT   = 2'b01;
    localparam logic [1:0] OUT_LT   = 2'b10;
    localparam logic [1:0] OUT_EQ   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       candidate;
    logic [1:0]       candidate_next;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic [RUN_W-1:0] run_inc;
    logic [1:0]       decision_next;

    logic [1:0]       sample_outcome;
    logic             sample_accept;
    logic             sample_bad;

    // Turn the raw comparator flags into an outcome code. The outcome codes
    // are chosen to match the decision encoding so they can be copied
    // straight into the decision register when a run completes.
`ifdef COMPARE_ONEHOT_CHECK_EN
    always_comb begin
        sample_outcome = OUT_NONE;
        sample_bad     = 1'b0;
        case ({A_gt_B, A_lt_B, A_eq_B})
            3'b100:  sample_outcome = OUT_GT;
            3'b010:  sample_outcome = OUT_LT;
            3'b001:  sample_outcome = OUT_EQ;
            default: sample_bad     = in_valid;
        endcase
        sample_accept = in_valid && (sample_outcome != OUT_NONE);
    end
`else
    always_comb begin
        sample_outcome = OUT_NONE;
        sample_bad     = 1'b0;
        if (A_eq_B) begin
            sample_outcome = OUT_EQ;
        end else if (A_gt_B) begin
            sample_outcome = OUT_GT;
        end else if (A_lt_B) begin
            sample_outcome = OUT_LT;
        end
        sample_accept = in_valid && (sample_outcome != OUT_NONE);
    end
`endif

    // Run tracker next-state logic. The decision is deliberately left alone
    // while in TRACK so a half-finished run of a new outcome never disturbs
    // what downstream logic sees; it only moves when a run reaches STABLE_N.
    // With STABLE_N == 1 every new outcome locks on the spot.
    always_comb begin
        state_next     = state;
        candidate_next = candidate;
        run_next       = run;
        decision_next  = decision;
        run_inc        = run + RUN_ONE;
        if (sample_accept) begin
            case (state)
                ST_IDLE: begin
                    candidate_next = sample_outcome;
                    run_next       = RUN_ONE;
                    if (STABLE_N == 1) begin
                        decision_next = sample_outcome;
                        state_next    = ST_LOCKED;
                    end else begin
                        state_next    = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (sample_outcome == candidate) begin
                        run_next = run_inc;
                        if (run_inc == RUN_MAX) begin
                            decision_next = candidate;
                            state_next    = ST_LOCKED;
                        end
                    end else begin
                        candidate_next = sample_outcome;
                        run_next       = RUN_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (sample_outcome != candidate) begin
                        candidate_next = sample_outcome;
                        run_next       = RUN_ONE;
                        if (STABLE_N == 1) begin
                            decision_next = sample_outcome;
                        end else begin
                            state_next    = ST_TRACK;
                        end
                    end
                end
                default: begin
                    state_next     = ST_IDLE;
                    candidate_next = OUT_NONE;
                    run_next       = '0;
                end
            endcase
        end
    end

    // State, decision and pulse registers. Comparing against the current
    // decision means re-locking the value already held gives no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            candidate       <= OUT_NONE;
            run             <= '0;
            decision        <= OUT_NONE;
            decision_valid  <= 1'b0;
            decision_change <= 1'b0;
        end else if (clear) begin
            state           <= ST_IDLE;
            candidate       <= OUT_NONE;
            run             <= '0;
            decision        <= OUT_NONE;
            decision_valid  <= 1'b0;
            decision_change <= 1'b0;
        end else begin
            state           <= state_next;
            candidate       <= candidate_next;
            run             <= run_next;
            decision        <= decision_next;
            decision_valid  <= (decision_next != OUT_NONE);
            decision_change <= (decision_next != decision);
        end
    end

    // Saturating per-outcome counters plus the sticky one-hot error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_count   <= '0;
            lt_count   <= '0;
            eq_count   <= '0;
            onehot_err <= 1'b0;
        end else if (clear) begin
            gt_count   <= '0;
            lt_count   <= '0;
            eq_count   <= '0;
            onehot_err <= 1'b0;
        end else begin
            if (sample_accept && (sample_outcome == OUT_GT) && (gt_count != CNT_MAX)) begin
                gt_count <= gt_count + 1'b1;
            end
            if (sample_accept && (sample_outcome == OUT_LT) && (lt_count != CNT_MAX)) begin
                lt_count <= lt_count + 1'b1;
            end
            if (sample_accept && (sample_outcome == OUT_EQ) && (eq_count != CNT_MAX)) begin
                eq_count <= eq_count + 1'b1;
            end
            if (sample_bad) begin
                onehot_err <= 1'b1;
            end
        end
    end

endmodule
